dram_port_arbiter: RTL
======================

// Module: dram_port_arbiter
// PURPOSE
//   Shares the single-port DRAM among the four matrix-multiplier cores.
//   - Sits directly downstream of the cores' DRAM request ports and upstream of the DRAM macro.
//   - Arbitrates read/write requests round-robin and drives one DRAM access at a time.
//   - Returns read data and a one-cycle acknowledge to the winning core.
// PARAMETERS
//   N_CORES       4    number of requesting cores; the flattened bus widths below assume 4
//   ADDR_W        16   DRAM address width
//   DATA_W        8    DRAM data width
//   READ_LATENCY  2    cycles from DRAM rden/address to valid i_mem_q; must be >= 1
// PORTS
//   i_clk        in   1       system clock (divided clock); single clock domain
//   i_rst        in   1       asynchronous, active-high reset
//   i_req_rd     in   4       per-core read request, level; held until ack
//   i_req_wr     in   4       per-core write request, level; held until ack
//   i_addr       in   64      core k address = i_addr[16k+15:16k]
//   i_wdata      in   32      core k write data = i_wdata[8k+7:8k]
//   o_ack        out  4       one-hot, one-cycle pulse: transaction for core k done
//   o_rdata      out  8       read data; valid when o_ack has a bit set for a read
//   o_busy       out  1       high whenever the FSM is not IDLE
//   o_mem_addr   out  16      DRAM address
//   o_mem_wdata  out  8       DRAM write data
//   o_mem_rden   out  1       DRAM read enable
//   o_mem_wren   out  1       DRAM write enable
//   i_mem_q      in   8       DRAM read data
// BEHAVIOUR
//   Reset: all outputs 0; FSM = IDLE; priority pointer = core 0; latch counter = 0.
//   FSM states:
//   - IDLE
//     - Core k is requesting when i_req_rd[k] | i_req_wr[k].
//     - If any core is requesting, pick the first requester at or after the pointer, wrapping 3->0.
//     - Latch the winner index, op, address and wdata; go to ISSUE.
//   - ISSUE (1 cycle)
//     - o_mem_addr/o_mem_wdata come from the latched values.
//     - Assert o_mem_wren for a write or o_mem_rden for a read, for exactly this cycle.
//     - Write: go to DONE. Read: go to WAIT and load the counter with READ_LATENCY-1.
//   - WAIT
//     - Decrement the counter each cycle.
//     - When it reaches 0, register i_mem_q into o_rdata and go to DONE.
//     - With READ_LATENCY=1, WAIT lasts 1 cycle.
//   - DONE (1 cycle)
//     - o_ack[winner]=1.
//     - Pointer = winner+1 mod 4, so the last winner gets lowest priority.
//     - Return to IDLE.
//   Timing:
//   - o_mem_rden/o_mem_wren are low outside ISSUE; o_mem_addr holds its value between accesses.
//   - Latency, request first sampled in IDLE at cycle 0:
//     - write: ack in cycle 2.
//     - read: ack in cycle 2+READ_LATENCY.
//   - Minimum inter-grant gap is 3 cycles: IDLE, ISSUE, DONE.
//   Handshake and boundary rules:
//   - Requester drops its req the cycle after seeing ack. A req still high in the following IDLE is
//     a new request and gets normal arbitration.
//   - Request inputs are ignored outside IDLE; address/data changes after latch have no effect.
//   - Same core asserts rd and wr together: the write is serviced. The read stays pending and
//     competes in a later round.
//   - o_rdata holds its last value until the next read completes; writes do not change it.
//   - Reset asserted mid-transaction: the transaction is aborted with no ack, and the DRAM enables
//     drop immediately (asynchronously).
//   - No requests: stay in IDLE, o_busy=0, pointer unchanged.
// TESTING
//   1. Write, then read back:
//      - core2 wr addr 0x0123, data 0xA5: o_mem_wren high 1 cycle with addr 0x0123/0xA5; o_ack=4'b0100 in cycle 2.
//      - core2 rd addr 0x0123: o_ack=4'b0100 in cycle 4 with o_rdata=0xA5.
//   2. All four cores read simultaneously from reset, addrs 0x10..0x13 holding 0x01..0x04:
//      - acks in order core0,1,2,3 carrying 0x01..0x04.
//      - Each ack is 5 cycles after the previous one.
//   3. Fairness: core0 re-requests immediately after each ack while core3 holds a request:
//      - grants alternate 0,3,0,3; core0 never wins twice in a row while core3 is pending.
//   4. core1 asserts rd and wr at addr 0x0040, wdata 0x5A:
//      - write ack first, then a read ack with o_rdata=0x5A.
//   5. Reset pulse during WAIT of a core0 read:
//      - no ack, all outputs 0, pointer=core0.
//      - The next request from core0 completes normally.
//   6. READ_LATENCY=1 build, core3 rd addr 0xFFFF holding 0x7E:
//      - o_ack=4'b1000 in cycle 3 with o_rdata=0x7E.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter giving four cores one-at-a-time access to a single-port DRAM.
// Write ack 2 cycles after the IDLE sample, read ack 2+READ_LATENCY; requests are held by the core until acked.
module dram_port_arbiter #(
  parameter int N_CORES      = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_CORES-1:0]        i_req_rd,
  input  logic [N_CORES-1:0]        i_req_wr,
  input  logic [N_CORES*ADDR_W-1:0] i_addr,
  input  logic [N_CORES*DATA_W-1:0] i_wdata,
  output logic [N_CORES-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_busy,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  output logic                      o_mem_rden,
  output logic                      o_mem_wren,
  input  logic [DATA_W-1:0]         i_mem_q
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [N_CORES-1:0]  req;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand;

  assign req = i_req_rd | i_req_wr;

  // Scan from the farthest offset down so the requester closest to the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      cand = IDX_W'((32'(ptr_q) + 32'(i)) % 32'(N_CORES));
      if (req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          // A simultaneous rd+wr from one core services the write; the read stays pending.
          win_d   = grant_idx;
          wr_d    = i_req_wr[grant_idx];
          addr_d  = i_addr[grant_idx*ADDR_W +: ADDR_W];
          wdata_d = i_wdata[grant_idx*DATA_W +: DATA_W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wr_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = i_mem_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        ptr_d   = (win_q == IDX_W'(N_CORES - 1)) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ack      = '0;
    o_busy     = (state_q != S_IDLE);
    o_mem_rden = (state_q == S_ISSUE) && !wr_q;
    o_mem_wren = (state_q == S_ISSUE) && wr_q;
    if (state_q == S_DONE) begin
      o_ack[win_q] = 1'b1;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;

endmodule
